// File: rtl/ysyx_22041412_seq_ctrl.sv
// Multi-cycle sequencer for the ysyx_22041412 core: walks fetch, decode, execute,
// memory and write-back for one instruction at a time, halting on ebreak or timeout.
module ysyx_22041412_seq_ctrl #(
  parameter logic [63:0] RESET_PC = 64'h8000_0000,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] next_pc,
  output logic [63:0] pc,
  output logic        if_req,
  input  logic        if_ready,
  input  logic        if_rvalid,
  input  logic [31:0] if_rdata,
  output logic [31:0] ir,
  input  logic [6:0]  dec_opcode,
  input  logic [3:0]  dec_type,
  output logic        ex_en,
  output logic        ls_req,
  output logic        ls_we,
  input  logic        ls_ready,
  input  logic        ls_rvalid,
  output logic        rf_we,
  output logic        pc_we,
  output logic        halt,
  output logic        err,
  output logic [63:0] instret
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_IF_REQ   = 4'd1,
    S_IF_WAIT  = 4'd2,
    S_ID       = 4'd3,
    S_EX       = 4'd4,
    S_MEM_REQ  = 4'd5,
    S_MEM_WAIT = 4'd6,
    S_WB       = 4'd7,
    S_HALT     = 4'd8
  } state_t;

  localparam logic [6:0]  OP_LOAD     = 7'b0000011;
  localparam logic [6:0]  OP_STORE    = 7'b0100011;
  localparam logic [6:0]  OP_SYSTEM   = 7'b1110011;
  localparam logic [31:0] EBREAK      = 32'h0010_0073;
  localparam logic [31:0] NOP         = 32'h0000_0013;
  localparam logic [3:0]  TYPE_BRANCH = 4'b0011;
  localparam logic [3:0]  TYPE_STORE  = 4'b0100;
  // The cycle in which the counter would reach TIMEOUT is the last one allowed.
  localparam logic [7:0]  WAIT_LAST   = 8'(TIMEOUT - 1);

  state_t     state;
  state_t     state_next;
  logic [7:0] wait_cnt;
  logic       in_wait;
  logic       wait_expired;
  logic       timeout_hit;
  logic       is_ebreak;
  logic       is_load;
  logic       is_store;
  logic       writes_rd;

  assign in_wait      = (state == S_IF_REQ)  || (state == S_IF_WAIT) ||
                        (state == S_MEM_REQ) || (state == S_MEM_WAIT);
  assign wait_expired = (wait_cnt == WAIT_LAST);
  assign is_ebreak    = (dec_opcode == OP_SYSTEM) && (ir == EBREAK);
  assign is_load      = (dec_opcode == OP_LOAD);
  assign is_store     = (dec_opcode == OP_STORE);
  assign writes_rd    = !((dec_type == TYPE_BRANCH) || (dec_type == TYPE_STORE));

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_next  = state;
    timeout_hit = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_next = S_IF_REQ;
      end
      S_IF_REQ: begin
        if (if_ready)          state_next  = S_IF_WAIT;
        else if (wait_expired) timeout_hit = 1'b1;
      end
      S_IF_WAIT: begin
        if (if_rvalid)         state_next  = S_ID;
        else if (wait_expired) timeout_hit = 1'b1;
      end
      S_ID: state_next = S_EX;
      S_EX: begin
        if (is_ebreak)               state_next = S_HALT;
        else if (is_load || is_store) state_next = S_MEM_REQ;
        else                         state_next = S_WB;
      end
      S_MEM_REQ: begin
        if (ls_ready)          state_next  = S_MEM_WAIT;
        else if (wait_expired) timeout_hit = 1'b1;
      end
      S_MEM_WAIT: begin
        if (ls_rvalid)         state_next  = S_WB;
        else if (wait_expired) timeout_hit = 1'b1;
      end
      S_WB:    state_next = S_IF_REQ;
      S_HALT:  state_next = S_HALT;
      default: state_next = S_IDLE;
    endcase
    if (timeout_hit) state_next = S_HALT;
  end

  // Outputs are registered from the next-state decode, so each one is high
  // for exactly the cycles the FSM spends in the matching state.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      pc       <= RESET_PC;
      ir       <= NOP;
      instret  <= '0;
      if_req   <= 1'b0;
      ls_req   <= 1'b0;
      ls_we    <= 1'b0;
      ex_en    <= 1'b0;
      rf_we    <= 1'b0;
      pc_we    <= 1'b0;
      halt     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state <= state_next;

      if (state_next != state) wait_cnt <= '0;
      else if (in_wait)        wait_cnt <= wait_cnt + 8'd1;

      if ((state == S_IF_WAIT) && if_rvalid) ir <= if_rdata;

      if (state == S_WB) begin
        pc      <= next_pc;
        instret <= instret + 64'd1;
      end

      if_req <= (state_next == S_IF_REQ);
      ls_req <= (state_next == S_MEM_REQ);
      ls_we  <= (state_next == S_MEM_REQ) && is_store;
      ex_en  <= (state_next == S_EX);
      pc_we  <= (state_next == S_WB);
      rf_we  <= (state_next == S_WB) && writes_rd;
      halt   <= (state_next == S_HALT);
      if (timeout_hit) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ysyx_22041412_seq_ctrl.sv
// Self-checking bench for ysyx_22041412_seq_ctrl: a bus responder per scenario and
// a queue of expected write-back results popped when the sequencer retires.
module tb_ysyx_22041412_seq_ctrl;

  localparam logic [63:0] RESET_PC = 64'h8000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] EBREAK   = 32'h0010_0073;

  logic        clk;
  logic        rst;
  logic        start;
  logic [63:0] next_pc;
  logic [63:0] pc;
  logic        if_req;
  logic        if_ready;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic [31:0] ir;
  logic [6:0]  dec_opcode;
  logic [3:0]  dec_type;
  logic        ex_en;
  logic        ls_req;
  logic        ls_we;
  logic        ls_ready;
  logic        ls_rvalid;
  logic        rf_we;
  logic        pc_we;
  logic        halt;
  logic        err;
  logic [63:0] instret;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_instret;
  logic [63:0] exp_pc;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] npc;
    logic        rf_we;
    logic        ls_we;
    int          cycles;
    int          ls_cycles;
    logic [63:0] instret;
  } exp_t;

  exp_t sb[$];

  // Decoder stand-in: opcode is the low seven bits of the latched instruction.
  assign dec_opcode = ir[6:0];

  ysyx_22041412_seq_ctrl #(
    .RESET_PC(RESET_PC),
    .TIMEOUT (255)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .next_pc   (next_pc),
    .pc        (pc),
    .if_req    (if_req),
    .if_ready  (if_ready),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .ir        (ir),
    .dec_opcode(dec_opcode),
    .dec_type  (dec_type),
    .ex_en     (ex_en),
    .ls_req    (ls_req),
    .ls_we     (ls_we),
    .ls_ready  (ls_ready),
    .ls_rvalid (ls_rvalid),
    .rf_we     (rf_we),
    .pc_we     (pc_we),
    .halt      (halt),
    .err       (err),
    .instret   (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic idle_inputs();
    start     = 1'b0;
    if_ready  = 1'b0;
    if_rvalid = 1'b0;
    if_rdata  = 32'hDEAD_BEEF;
    ls_ready  = 1'b0;
    ls_rvalid = 1'b0;
  endtask

  // Leaves the caller at a falling edge with rst just released.
  task automatic apply_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_instret = '0;
    exp_pc      = RESET_PC;
  endtask

  // Runs one non-ebreak instruction from its first IF_REQ cycle through WB,
  // returning at #1 after the edge that ends WB.
  task automatic run_instr(input logic [31:0] instr, input logic [3:0] dtype,
                           input logic [63:0] npc, input int if_dly, input int ls_dly,
                           input bit early_rvalid);
    exp_t e;
    exp_t got;
    bit   mem;
    bit   done = 0;
    bit   if_acc = 0;
    bit   ls_acc = 0;
    bit   overlap = 0;
    int   cyc = 0;
    int   if_wait = 0;
    int   ls_wait = 0;
    int   ls_cnt = 0;
    int   exen_cnt = 0;
    logic ls_we_seen = 1'b0;

    dec_type = dtype;
    next_pc  = npc;
    mem      = (instr[6:0] == 7'b0000011) || (instr[6:0] == 7'b0100011);
    e.instr     = instr;
    e.npc       = npc;
    e.rf_we     = !((dtype == 4'b0011) || (dtype == 4'b0100));
    e.ls_we     = (instr[6:0] == 7'b0100011);
    e.cycles    = 5 + if_dly + (mem ? 2 + ls_dly : 0);
    e.ls_cycles = mem ? 1 + ls_dly : 0;
    exp_instret = exp_instret + 64'd1;
    e.instret   = exp_instret;
    sb.push_back(e);

    while (!done && cyc < 300) begin
      @(negedge clk);
      cyc++;
      idle_inputs();
      if (if_req && ls_req) overlap = 1;
      if (if_acc) begin
        if_rvalid = 1'b1;
        if_rdata  = instr;
        if_acc    = 0;
      end else if (if_req) begin
        if (if_wait == if_dly) begin
          if_ready = 1'b1;
          if_acc   = 1;
          if (early_rvalid) begin
            if_rvalid = 1'b1;
            if_rdata  = ~instr;
          end
        end else begin
          if_wait++;
        end
      end
      if (ls_acc) begin
        ls_rvalid = 1'b1;
        ls_acc    = 0;
      end else if (ls_req) begin
        ls_cnt++;
        ls_we_seen = ls_we;
        if (ls_wait == ls_dly) begin
          ls_ready = 1'b1;
          ls_acc   = 1;
        end else begin
          ls_wait++;
        end
      end
      if (ex_en) exen_cnt++;
      if (pc_we) begin
        done = 1;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL scoreboard_empty: retire seen with no expected entry");
        end else begin
          got = sb.pop_front();
          checks++;
          if (cyc !== got.cycles) begin
            errors++;
            $display("FAIL latency %h: got %0d cycles, want %0d", instr, cyc, got.cycles);
          end
          checks++;
          if (rf_we !== got.rf_we) begin
            errors++;
            $display("FAIL rf_we %h: got %b, want %b", instr, rf_we, got.rf_we);
          end
          checks++;
          if (ls_cnt !== got.ls_cycles || ls_we_seen !== got.ls_we) begin
            errors++;
            $display("FAIL ls_req %h: got %0d cycles we=%b, want %0d cycles we=%b",
                     instr, ls_cnt, ls_we_seen, got.ls_cycles, got.ls_we);
          end
          checks++;
          if (exen_cnt !== 1 || ir !== got.instr || overlap) begin
            errors++;
            $display("FAIL exec %h: ex_en cycles %0d ir %h overlap %b, want 1 %h 0",
                     instr, exen_cnt, ir, overlap, got.instr);
          end
          checks++;
          if (pc !== exp_pc) begin
            errors++;
            $display("FAIL pc_before_wb %h: got %h, want %h", instr, pc, exp_pc);
          end
          @(posedge clk);
          #1;
          exp_pc = got.npc;
          checks++;
          if (pc !== got.npc || instret !== got.instret) begin
            errors++;
            $display("FAIL retire %h: pc %h instret %0d, want %h %0d",
                     instr, pc, instret, got.npc, got.instret);
          end
          checks++;
          if ({pc_we, rf_we, ex_en} !== 3'b000) begin
            errors++;
            $display("FAIL pulse_width %h: pc_we/rf_we/ex_en %b after WB, want 000",
                     instr, {pc_we, rf_we, ex_en});
          end
        end
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL retire_timeout %h: no pc_we within %0d cycles", instr, cyc);
    end
  endtask

  task automatic test_reset();
    bit busy = 0;
    apply_reset();
    checks++;
    if (pc !== RESET_PC || ir !== NOP || instret !== 64'd0) begin
      errors++;
      $display("FAIL reset_regs: pc %h ir %h instret %0d, want %h %h 0",
               pc, ir, instret, RESET_PC, NOP);
    end
    checks++;
    if ({if_req, ls_req, ls_we, ex_en, rf_we, pc_we, halt, err} !== 8'h00) begin
      errors++;
      $display("FAIL reset_bits: got %b, want 00000000",
               {if_req, ls_req, ls_we, ex_en, rf_we, pc_we, halt, err});
    end
    repeat (3) begin
      @(negedge clk);
      if (if_req || ls_req) busy = 1;
    end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL idle_without_start: request raised, want none");
    end
  endtask

  task automatic test_alu();
    start = 1'b1;
    run_instr(32'h0010_0093, 4'b0001, 64'h8000_0004, 0, 0, 0);
  endtask

  task automatic test_store();
    run_instr(32'h00B5_3023, 4'b0100, 64'h8000_0008, 0, 3, 0);
  endtask

  task automatic test_load();
    run_instr(32'h0005_3503, 4'b0001, 64'h8000_000C, 0, 0, 0);
  endtask

  task automatic test_branch();
    run_instr(32'h0E00_0063, 4'b0011, 64'h8000_0100, 0, 0, 0);
  endtask

  // Early fetch data arriving with acceptance must be dropped; the next
  // instruction follows immediately with no gap.
  task automatic test_back_to_back();
    run_instr(32'h0020_8113, 4'b0001, 64'h8000_0104, 2, 0, 1);
    run_instr(32'h0031_01B3, 4'b0010, 64'h8000_0108, 0, 0, 1);
  endtask

  task automatic test_ebreak();
    bit if_acc = 0;
    bit bad = 0;
    int cyc = 0;
    int exen_cnt = 0;
    int pcwe_cnt = 0;
    dec_type = 4'b0001;
    while (cyc < 50) begin
      @(negedge clk);
      cyc++;
      idle_inputs();
      if (halt) break;
      if (if_acc) begin
        if_rvalid = 1'b1;
        if_rdata  = EBREAK;
        if_acc    = 0;
      end else if (if_req) begin
        if_ready = 1'b1;
        if_acc   = 1;
      end
      if (ex_en) exen_cnt++;
      if (pc_we) pcwe_cnt++;
    end
    checks++;
    if (!halt || cyc !== 5 || err !== 1'b0) begin
      errors++;
      $display("FAIL ebreak_halt: halt %b err %b at cycle %0d, want 1 0 at 5", halt, err, cyc);
    end
    checks++;
    if (exen_cnt !== 1 || pcwe_cnt !== 0) begin
      errors++;
      $display("FAIL ebreak_pulses: ex_en %0d pc_we %0d, want 1 0", exen_cnt, pcwe_cnt);
    end
    repeat (10) begin
      start     = 1'b1;
      if_ready  = 1'b1;
      if_rvalid = 1'b1;
      if_rdata  = NOP;
      ls_ready  = 1'b1;
      ls_rvalid = 1'b1;
      @(negedge clk);
      if (!halt || if_req || ls_req || ex_en || rf_we || pc_we) bad = 1;
    end
    idle_inputs();
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL halt_absorbing: sequencer left HALT or raised a request");
    end
    checks++;
    if (instret !== exp_instret || pc !== exp_pc || ir !== EBREAK) begin
      errors++;
      $display("FAIL ebreak_state: instret %0d pc %h ir %h, want %0d %h %h",
               instret, pc, ir, exp_instret, exp_pc, EBREAK);
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    int cyc = 0;
    apply_reset();
    checks++;
    if (halt !== 1'b0) begin
      errors++;
      $display("FAIL reset_from_halt: halt %b, want 0", halt);
    end
    start = 1'b1;
    while (cyc < 400) begin
      @(negedge clk);
      cyc++;
      idle_inputs();
      if (halt) break;
      if (if_req) n++;
    end
    checks++;
    if (n !== 255 || halt !== 1'b1 || err !== 1'b1) begin
      errors++;
      $display("FAIL timeout: if_req cycles %0d halt %b err %b, want 255 1 1", n, halt, err);
    end
    checks++;
    if (if_req !== 1'b0 || pc !== RESET_PC) begin
      errors++;
      $display("FAIL timeout_state: if_req %b pc %h, want 0 %h", if_req, pc, RESET_PC);
    end
  endtask

  task automatic test_reset_mid();
    bit if_acc = 0;
    bit ls_acc = 0;
    bit hit = 0;
    bit busy = 0;
    int cyc = 0;
    apply_reset();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (if_req !== 1'b1) begin
      errors++;
      $display("FAIL start_from_idle: if_req %b, want 1", if_req);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (if_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_drops_if_req: if_req %b, want 0", if_req);
    end
    dec_type = 4'b0001;
    next_pc  = 64'h8000_0010;
    start    = 1'b1;
    while (cyc < 50) begin
      @(negedge clk);
      cyc++;
      idle_inputs();
      if (ls_acc) begin
        rst = 1'b1;
        hit = 1;
        break;
      end
      if (if_acc) begin
        if_rvalid = 1'b1;
        if_rdata  = 32'h0000_3083;
        if_acc    = 0;
      end else if (if_req) begin
        if_ready = 1'b1;
        if_acc   = 1;
      end
      if (ls_req) begin
        ls_ready = 1'b1;
        ls_acc   = 1;
      end
    end
    @(negedge clk);
    rst       = 1'b0;
    ls_rvalid = 1'b1;
    checks++;
    if (!hit || ls_req !== 1'b0 || if_req !== 1'b0 || pc !== RESET_PC ||
        ir !== NOP || instret !== 64'd0) begin
      errors++;
      $display("FAIL reset_mid: reached %b ls_req %b if_req %b pc %h ir %h instret %0d, want 1 0 0 %h %h 0",
               hit, ls_req, if_req, pc, ir, instret, RESET_PC, NOP);
    end
    repeat (3) begin
      @(negedge clk);
      ls_rvalid = 1'b0;
      if (if_req || ls_req || rf_we || pc_we || ex_en || halt) busy = 1;
    end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL late_response: activity after reset, want IDLE");
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (if_req !== 1'b1) begin
      errors++;
      $display("FAIL idle_after_reset: if_req %b after start, want 1", if_req);
    end
  endtask

  initial begin
    rst      = 1'b1;
    next_pc  = '0;
    dec_type = '0;
    idle_inputs();
    test_reset();
    test_alu();
    test_store();
    test_load();
    test_branch();
    test_back_to_back();
    test_ebreak();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
